// File: rtl/dda_pkg.sv
// Shared defaults and segment sizing for the DDA segment queue.
package dda_pkg;

    localparam int DDA_DW     = 32;
    localparam int DDA_N_AXES = 4;
    localparam int DDA_DEPTH  = 8;

    // One segment word: time, then all positions, then all velocities.
    function automatic int seg_width(input int n_axes, input int dw);
        return n_axes * 2 * dw + dw;
    endfunction

endpackage

// File: rtl/dda_seg_queue_if.sv
// Segment channel from the queue head to the DDA core (valid/ready).
interface dda_seg_queue_if
    import dda_pkg::*;
#(
    parameter int DW     = DDA_DW,
    parameter int N_AXES = DDA_N_AXES
);

    logic                   seg_valid;
    logic                   seg_ready;
    logic [DW-1:0]          seg_time;
    logic [N_AXES*DW-1:0]   seg_position;
    logic [N_AXES*DW-1:0]   seg_velocity;

    modport master (
        output seg_valid,
        output seg_time,
        output seg_position,
        output seg_velocity,
        input  seg_ready
    );

    modport slave (
        input  seg_valid,
        input  seg_time,
        input  seg_position,
        input  seg_velocity,
        output seg_ready
    );

endinterface

// File: rtl/dda_seg_fifo.sv
// Generic synchronous FIFO with flush and show-ahead read data.
module dda_seg_fifo
    import dda_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = DDA_DEPTH,
    parameter int LVL_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic                flush,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [WIDTH-1:0]    rd_data,
    output logic [LVL_BITS-1:0] level,
    output logic                full,
    output logic                empty,
    output logic                pop
);

    localparam int PTR_W = LVL_BITS - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;

    assign full    = (level == LVL_BITS'(DEPTH));
    assign empty   = (level == '0);
    assign pop     = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push    = wr_en && (!full || pop);
    assign rd_data = mem[rd_ptr];

    // Storage write; flush suppresses the write along with everything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_BITS'(1);
                2'b01:   level <= level - LVL_BITS'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dda_seg_queue.sv
// Host staging registers feeding a queue of motion segments for the DDA core.
module dda_seg_queue
    import dda_pkg::*;
#(
    parameter int DW        = DDA_DW,
    parameter int N_AXES    = DDA_N_AXES,
    parameter int AXIS_BITS = 2,
    parameter int DEPTH     = DDA_DEPTH,
    parameter int LVL_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW-1:0]        data_in,
    input  logic [AXIS_BITS-1:0] axis_sel,
    input  logic                 set_target_time,
    input  logic                 set_target_position,
    input  logic                 set_target_velocity,
    input  logic                 commit,
    input  logic                 flush,
    input  logic                 clear_err,
    dda_seg_queue_if.master      seg_if,
    output logic [LVL_BITS-1:0]  level,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow
);

    localparam int SEG_W   = seg_width(N_AXES, DW);
    localparam int POS_LSB = DW;
    localparam int VEL_LSB = DW + N_AXES * DW;

    logic [DW-1:0]     stage_time;
    logic [DW-1:0]     stage_pos [N_AXES];
    logic [DW-1:0]     stage_vel [N_AXES];
    logic [N_AXES-1:0] axis_hit;
    logic [SEG_W-1:0]  stage_word;
    logic [SEG_W-1:0]  head_word;
    logic              fifo_pop;

    // Axis decode; selects beyond N_AXES hit nothing and are ignored.
    always_comb begin
        axis_hit = '0;
        for (int k = 0; k < N_AXES; k++) begin
            if (axis_sel == AXIS_BITS'(k)) begin
                axis_hit[k] = 1'b1;
            end
        end
    end

    // Staging registers; commit and flush never touch them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_time <= '0;
            for (int k = 0; k < N_AXES; k++) begin
                stage_pos[k] <= '0;
                stage_vel[k] <= '0;
            end
        end else begin
            if (set_target_time) begin
                stage_time <= data_in;
            end
            for (int k = 0; k < N_AXES; k++) begin
                if (set_target_position && axis_hit[k]) begin
                    stage_pos[k] <= data_in;
                end
                if (set_target_velocity && axis_hit[k]) begin
                    stage_vel[k] <= data_in;
                end
            end
        end
    end

    // Flatten staging into one FIFO word (pre-edge values, so same-cycle writes go to the next segment).
    always_comb begin
        stage_word = '0;
        stage_word[DW-1:0] = stage_time;
        for (int k = 0; k < N_AXES; k++) begin
            stage_word[POS_LSB + k*DW +: DW] = stage_pos[k];
            stage_word[VEL_LSB + k*DW +: DW] = stage_vel[k];
        end
    end

    dda_seg_fifo #(
        .WIDTH    (SEG_W),
        .DEPTH    (DEPTH),
        .LVL_BITS (LVL_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (commit),
        .rd_en   (seg_if.seg_ready),
        .flush   (flush),
        .wr_data (stage_word),
        .rd_data (head_word),
        .level   (level),
        .full    (full),
        .empty   (empty),
        .pop     (fifo_pop)
    );

    // Sticky drop flag; a drop in the same cycle as clear_err keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (commit && full && !fifo_pop) begin
            overflow <= 1'b1;
        end else if (clear_err) begin
            overflow <= 1'b0;
        end
    end

    assign seg_if.seg_valid    = !empty;
    assign seg_if.seg_time     = head_word[DW-1:0];
    assign seg_if.seg_position = head_word[POS_LSB +: N_AXES*DW];
    assign seg_if.seg_velocity = head_word[VEL_LSB +: N_AXES*DW];

endmodule

// File: tb/tb_dda_seg_queue.sv
// Scoreboard bench for dda_seg_queue.
module tb_dda_seg_queue;

    localparam int DW    = 32;
    localparam int NA    = 4;
    localparam int AB    = 3;
    localparam int DEPTH = 8;
    localparam int LB    = 4;

    typedef struct packed {
        logic [NA-1:0][DW-1:0] v;
        logic [NA-1:0][DW-1:0] p;
        logic [DW-1:0]         t;
    } seg_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] data_in;
    logic [AB-1:0] axis_sel;
    logic          set_target_time;
    logic          set_target_position;
    logic          set_target_velocity;
    logic          commit;
    logic          flush;
    logic          clear_err;
    logic [LB-1:0] level;
    logic          full;
    logic          empty;
    logic          overflow;

    dda_seg_queue_if #(.DW(DW), .N_AXES(NA)) seg_if ();

    dda_seg_queue #(
        .DW(DW), .N_AXES(NA), .AXIS_BITS(AB), .DEPTH(DEPTH), .LVL_BITS(LB)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .data_in             (data_in),
        .axis_sel            (axis_sel),
        .set_target_time     (set_target_time),
        .set_target_position (set_target_position),
        .set_target_velocity (set_target_velocity),
        .commit              (commit),
        .flush               (flush),
        .clear_err           (clear_err),
        .seg_if              (seg_if),
        .level               (level),
        .full                (full),
        .empty               (empty),
        .overflow            (overflow)
    );

    seg_t        stage_m;
    seg_t        q[$];
    logic [31:0] popped[$];
    bit          ovf_m;
    int          total;
    int          bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        data_in             = '0;
        axis_sel            = '0;
        set_target_time     = 1'b0;
        set_target_position = 1'b0;
        set_target_velocity = 1'b0;
        commit              = 1'b0;
        flush               = 1'b0;
        clear_err           = 1'b0;
        seg_if.seg_ready    = 1'b0;
    endtask

    // Check outputs against the model, advance the model by one edge, then clock.
    task automatic step();
        bit mfull;
        bit mpop;
        int a;
        @(negedge clk);
        chk("level", 64'(level), 64'(q.size()));
        chk("valid", 64'(seg_if.seg_valid), 64'(q.size() != 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        if (q.size() != 0) begin
            chk("head_time", 64'(seg_if.seg_time), 64'(q[0].t));
            for (int k = 0; k < NA; k++) begin
                chk($sformatf("head_pos%0d", k), 64'(seg_if.seg_position[k*DW +: DW]), 64'(q[0].p[k]));
                chk($sformatf("head_vel%0d", k), 64'(seg_if.seg_velocity[k*DW +: DW]), 64'(q[0].v[k]));
            end
        end
        mfull = (q.size() == DEPTH);
        mpop  = (q.size() != 0) && seg_if.seg_ready;
        if (commit && mfull && !mpop) ovf_m = 1'b1;
        else if (clear_err)           ovf_m = 1'b0;
        if (flush) begin
            q.delete();
        end else begin
            if (mpop) begin
                popped.push_back(q[0].t);
                void'(q.pop_front());
            end
            if (commit && (!mfull || mpop)) q.push_back(stage_m);
        end
        a = int'(axis_sel);
        if (set_target_time) stage_m.t = data_in;
        if (set_target_position && a < NA) stage_m.p[a] = data_in;
        if (set_target_velocity && a < NA) stage_m.v[a] = data_in;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic set_t(input logic [31:0] val);
        set_target_time = 1'b1;
        data_in = val;
        step();
    endtask

    task automatic set_p(input int ax, input logic [31:0] val);
        axis_sel = AB'(ax);
        set_target_position = 1'b1;
        data_in = val;
        step();
    endtask

    task automatic set_v(input int ax, input logic [31:0] val);
        axis_sel = AB'(ax);
        set_target_velocity = 1'b1;
        data_in = val;
        step();
    endtask

    task automatic do_commit(input bit rdy);
        commit = 1'b1;
        seg_if.seg_ready = rdy;
        step();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 40) begin
            seg_if.seg_ready = 1'b1;
            step();
            g++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        ovf_m   = 1'b0;
        stage_m = '0;
        clear_inputs();
        reset = 1'b1;
        #2 reset = 1'b0;
        #10;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(seg_if.seg_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_time", 64'(seg_if.seg_time), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // basic segment
        set_t(100);
        for (int k = 0; k < NA; k++) set_p(k, 32'((k + 1) * 10));
        for (int k = 0; k < NA; k++) set_v(k, 32'(k + 1));
        do_commit(1'b0);
        chk("t1_valid", 64'(seg_if.seg_valid), 64'd1);
        chk("t1_time", 64'(seg_if.seg_time), 64'd100);
        chk("t1_pos2", 64'(seg_if.seg_position[2*DW +: DW]), 64'd30);
        chk("t1_level", 64'(level), 64'd1);
        seg_if.seg_ready = 1'b1;
        step();
        chk("t1_pop_level", 64'(level), 64'd0);
        chk("t1_pop_valid", 64'(seg_if.seg_valid), 64'd0);

        // same-cycle write and commit, out-of-range axis
        set_t(5);
        commit = 1'b1;
        set_target_time = 1'b1;
        data_in = 9;
        step();
        do_commit(1'b0);
        chk("t2_head_time", 64'(seg_if.seg_time), 64'd5);
        set_p(5, 32'hdead);
        set_v(5, 32'hbeef);
        do_commit(1'b0);
        drain();

        // fill, overflow, replace while full, clear_err
        for (int i = 0; i < DEPTH; i++) begin
            commit = 1'b1;
            set_target_time = 1'b1;
            data_in = 32'(201 + i);
            step();
        end
        chk("t3_full", 64'(full), 64'd1);
        do_commit(1'b0);
        chk("t3_ovf", 64'(overflow), 64'd1);
        chk("t3_level", 64'(level), 64'd8);
        chk("t3_head", 64'(seg_if.seg_time), 64'd9);
        set_t(32'h77);
        do_commit(1'b1);
        chk("t3_level_swap", 64'(level), 64'd8);
        clear_err = 1'b1;
        step();
        chk("t3_clear", 64'(overflow), 64'd0);
        drain();
        chk("t3_tail", 64'(popped[popped.size() - 1]), 64'h77);

        // wrap-around with commit/pop pairs
        popped.delete();
        for (int i = 1; i <= 20; i++) begin
            set_t(32'(i));
            do_commit(1'b1);
            if (i == 1) begin
                chk("t4_empty_commit_valid", 64'(seg_if.seg_valid), 64'd1);
                chk("t4_empty_commit_level", 64'(level), 64'd1);
            end
        end
        drain();
        chk("t4_count", 64'(popped.size()), 64'd20);
        for (int i = 0; i < popped.size(); i++) begin
            chk($sformatf("t4_order%0d", i), 64'(popped[i]), 64'(i + 1));
        end

        // flush beats commit and pop; staging survives
        for (int i = 0; i < 4; i++) do_commit(1'b0);
        flush = 1'b1;
        commit = 1'b1;
        seg_if.seg_ready = 1'b1;
        step();
        chk("t5_level", 64'(level), 64'd0);
        chk("t5_valid", 64'(seg_if.seg_valid), 64'd0);
        do_commit(1'b0);
        chk("t5_time", 64'(seg_if.seg_time), 64'd20);
        chk("t5_pos3", 64'(seg_if.seg_position[3*DW +: DW]), 64'd40);
        drain();

        // reset mid-queue with overflow set and 3 entries queued
        for (int i = 0; i < DEPTH + 1; i++) do_commit(1'b0);
        for (int i = 0; i < 5; i++) begin
            seg_if.seg_ready = 1'b1;
            step();
        end
        chk("t6_pre_level", 64'(level), 64'd3);
        #2 reset = 1'b0;
        #1;
        chk("t6_level", 64'(level), 64'd0);
        chk("t6_valid", 64'(seg_if.seg_valid), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_time", 64'(seg_if.seg_time), 64'd0);
        q.delete();
        stage_m = '0;
        ovf_m = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_commit(1'b0);
        step();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
